// File: rtl/vtc_pkg.sv
// Shared types, mode table and test-pattern colours for the multimode video timing controller.
package vtc_pkg;

    localparam int VTC_CNT_W    = 12;
    localparam int VTC_MODE_MAX = 4;

    typedef enum logic {
        VTC_IDLE = 1'b0,
        VTC_RUN  = 1'b1
    } vtc_state_e;

    typedef struct packed {
        logic [VTC_CNT_W-1:0] h_active;
        logic [VTC_CNT_W-1:0] h_sync_start;
        logic [VTC_CNT_W-1:0] h_sync_end;
        logic [VTC_CNT_W-1:0] h_frame;
        logic [VTC_CNT_W-1:0] v_active;
        logic [VTC_CNT_W-1:0] v_sync_start;
        logic [VTC_CNT_W-1:0] v_sync_end;
        logic [VTC_CNT_W-1:0] v_frame;
        logic                 h_pol;
        logic                 v_pol;
    } vtc_mode_t;

    // Entry 2 is a short 16x8 diagnostic raster for bring-up/loopback; entry 3 is 640x480.
    localparam vtc_mode_t VTC_MODE_TABLE [VTC_MODE_MAX] = '{
        '{12'd1280, 12'd1328, 12'd1440, 12'd1688, 12'd1024, 12'd1025, 12'd1028, 12'd1066, 1'b1, 1'b1},
        '{12'd1280, 12'd1390, 12'd1430, 12'd1650, 12'd720,  12'd725,  12'd730,  12'd750,  1'b1, 1'b1},
        '{12'd16,   12'd18,   12'd20,   12'd24,   12'd8,    12'd9,    12'd10,   12'd12,   1'b0, 1'b0},
        '{12'd640,  12'd656,  12'd752,  12'd800,  12'd480,  12'd490,  12'd492,  12'd525,  1'b0, 1'b0}
    };

    localparam logic [23:0] VTC_BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] VTC_BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] VTC_BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] VTC_BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] VTC_BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] VTC_BAR_RED     = 24'hFF0000;
    localparam logic [23:0] VTC_BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] VTC_BAR_BLACK   = 24'h000000;

    localparam logic [23:0] VTC_BAR_COLOR [8] = '{
        VTC_BAR_WHITE, VTC_BAR_YELLOW, VTC_BAR_CYAN, VTC_BAR_GREEN,
        VTC_BAR_MAGENTA, VTC_BAR_RED, VTC_BAR_BLUE, VTC_BAR_BLACK
    };

    function automatic logic [VTC_CNT_W-1:0] vtc_bar_width(input vtc_mode_t m);
        return m.h_active >> 3;
    endfunction

endpackage

// File: rtl/vtc_delay_line.sv
// Fixed-depth shift register with a loadable reset value; aligns Pre-side signals to the Post side.
module vtc_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_val;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vtc_multimode_gen.sv
// Multimode video timing generator: Pre timing for the read path, Post timing PRE_LEAD cycles later.
// Optional colour-bar test pattern on O_Tpg_Data when VTC_TPG_EN is defined.
//
// state    | meaning
// VTC_IDLE | counters held at (0,0), outputs inactive; mode sampled when enable rises
// VTC_RUN  | raster running; mode re-sampled at the last pixel of each frame
module vtc_multimode_gen
    import vtc_pkg::*;
#(
    parameter int MODE_NUM = 2,
    parameter int PRE_LEAD = 2,
    parameter int CNT_W    = 12
) (
    input  logic             Pixl_CLK,
    input  logic             Rst_n,
    input  logic             I_Enable,
    input  logic [1:0]       I_Mode_Sel,
    output logic             O_Pre_De,
    output logic             O_Pre_Vsync,
    output logic             O_Pre_Hsync,
    output logic             O_Post_De,
    output logic             O_Post_Vsync,
    output logic             O_Post_Hsync,
    output logic [CNT_W-1:0] O_H_Cnt,
    output logic [CNT_W-1:0] O_V_Cnt,
    output logic             O_Frame_Start,
    output logic [1:0]       O_Mode_Active,
    output logic [23:0]      O_Tpg_Data
);

    localparam logic [2:0] MODE_LIM = 3'(MODE_NUM);

    vtc_state_e       state_q, state_nxt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] h_cnt_q, v_cnt_q, h_cnt_nxt, v_cnt_nxt;
    logic             run_act, mode_load, mode_ok, line_end, frame_end;
    logic             de_raw, hs_raw, vs_raw;
    vtc_mode_t        mode_cfg;
    logic [CNT_W-1:0] h_act, h_ss, h_se, h_last, v_act, v_ss, v_se, v_last;
    logic [2:0]       post_bus;

    assign mode_cfg = VTC_MODE_TABLE[mode_q];
    assign h_act    = CNT_W'(mode_cfg.h_active);
    assign h_ss     = CNT_W'(mode_cfg.h_sync_start);
    assign h_se     = CNT_W'(mode_cfg.h_sync_end);
    assign h_last   = CNT_W'(mode_cfg.h_frame - VTC_CNT_W'(1));
    assign v_act    = CNT_W'(mode_cfg.v_active);
    assign v_ss     = CNT_W'(mode_cfg.v_sync_start);
    assign v_se     = CNT_W'(mode_cfg.v_sync_end);
    assign v_last   = CNT_W'(mode_cfg.v_frame - VTC_CNT_W'(1));

    assign mode_ok   = ({1'b0, I_Mode_Sel} < MODE_LIM);
    assign line_end  = (h_cnt_q == h_last);
    assign frame_end = line_end && (v_cnt_q == v_last);

    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= VTC_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            VTC_IDLE: if (I_Enable)  state_nxt = VTC_RUN;
            VTC_RUN:  if (!I_Enable) state_nxt = VTC_IDLE;
            default:  state_nxt = VTC_IDLE;
        endcase
    end

    always_comb begin
        run_act   = 1'b0;
        mode_load = 1'b0;
        case (state_q)
            VTC_IDLE: mode_load = I_Enable;
            VTC_RUN: begin
                run_act   = I_Enable;
                mode_load = I_Enable && frame_end;
            end
            default: ;
        endcase
    end

    always_comb begin
        h_cnt_nxt = '0;
        v_cnt_nxt = '0;
        if (run_act) begin
            if (!line_end) begin
                h_cnt_nxt = h_cnt_q + CNT_W'(1);
                v_cnt_nxt = v_cnt_q;
            end else if (!frame_end) begin
                v_cnt_nxt = v_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= 2'd0;
        end else begin
            h_cnt_q <= h_cnt_nxt;
            v_cnt_q <= v_cnt_nxt;
            if (mode_load && mode_ok) begin
                mode_q <= I_Mode_Sel;
            end
        end
    end

    assign de_raw = (h_cnt_q < h_act) && (v_cnt_q < v_act);
    assign hs_raw = (h_cnt_q >= h_ss) && (h_cnt_q < h_se);
    assign vs_raw = (v_cnt_q >= v_ss) && (v_cnt_q < v_se);

    // Mode is registered alongside the Pre outputs so it flips together with O_Frame_Start.
    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            O_Pre_De      <= 1'b0;
            O_Pre_Vsync   <= 1'b0;
            O_Pre_Hsync   <= 1'b0;
            O_H_Cnt       <= '0;
            O_V_Cnt       <= '0;
            O_Frame_Start <= 1'b0;
            O_Mode_Active <= 2'd0;
        end else begin
            O_Pre_De      <= run_act && de_raw;
            O_Pre_Hsync   <= (run_act && hs_raw) ? mode_cfg.h_pol : ~mode_cfg.h_pol;
            O_Pre_Vsync   <= (run_act && vs_raw) ? mode_cfg.v_pol : ~mode_cfg.v_pol;
            O_H_Cnt       <= run_act ? h_cnt_q : '0;
            O_V_Cnt       <= run_act ? v_cnt_q : '0;
            O_Frame_Start <= run_act && (h_cnt_q == '0) && (v_cnt_q == '0);
            O_Mode_Active <= mode_q;
        end
    end

    vtc_delay_line #(
        .DEPTH (PRE_LEAD),
        .WIDTH (3)
    ) u_post_dly (
        .clk_sys (Pixl_CLK),
        .rst_b   (Rst_n),
        .rst_val (3'b000),
        .din     ({O_Pre_De, O_Pre_Vsync, O_Pre_Hsync}),
        .dout    (post_bus)
    );

    assign {O_Post_De, O_Post_Vsync, O_Post_Hsync} = post_bus;

`ifdef VTC_TPG_EN
    logic [CNT_W-1:0] bar_cnt_q, bar_w_last;
    logic [2:0]       bar_idx_q;
    logic [23:0]      tpg_pre_q;

    assign bar_w_last = CNT_W'(vtc_bar_width(mode_cfg) - VTC_CNT_W'(1));

    // Bar position tracks h_cnt_q; it restarts whenever the next pixel is a line start.
    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= 3'd0;
            tpg_pre_q <= 24'd0;
        end else begin
            tpg_pre_q <= (run_act && de_raw) ? VTC_BAR_COLOR[bar_idx_q] : 24'd0;
            if (h_cnt_nxt == '0) begin
                bar_cnt_q <= '0;
                bar_idx_q <= 3'd0;
            end else if (bar_cnt_q == bar_w_last) begin
                bar_cnt_q <= '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_q <= bar_idx_q + 3'd1;
                end
            end else begin
                bar_cnt_q <= bar_cnt_q + CNT_W'(1);
            end
        end
    end

    vtc_delay_line #(
        .DEPTH (PRE_LEAD),
        .WIDTH (24)
    ) u_tpg_dly (
        .clk_sys (Pixl_CLK),
        .rst_b   (Rst_n),
        .rst_val (24'd0),
        .din     (tpg_pre_q),
        .dout    (O_Tpg_Data)
    );
`else
    assign O_Tpg_Data = 24'd0;
`endif

endmodule

// File: tb/tb_vtc_multimode_gen.sv
// Directed bench for vtc_multimode_gen: per-mode line table plus frame, enable, reset and pattern sequences.
`timescale 1ns/1ps
module tb_vtc_multimode_gen;

    localparam int CNT_W    = 12;
    localparam int PRE_LEAD = 5;
    localparam int MODE_NUM = 3;

    logic             Pixl_CLK = 1'b0;
    logic             Rst_n;
    logic             I_Enable;
    logic [1:0]       I_Mode_Sel;
    logic             O_Pre_De, O_Pre_Vsync, O_Pre_Hsync;
    logic             O_Post_De, O_Post_Vsync, O_Post_Hsync;
    logic [CNT_W-1:0] O_H_Cnt, O_V_Cnt;
    logic             O_Frame_Start;
    logic [1:0]       O_Mode_Active;
    logic [23:0]      O_Tpg_Data;

    vtc_multimode_gen #(
        .MODE_NUM (MODE_NUM),
        .PRE_LEAD (PRE_LEAD),
        .CNT_W    (CNT_W)
    ) dut (
        .Pixl_CLK      (Pixl_CLK),
        .Rst_n         (Rst_n),
        .I_Enable      (I_Enable),
        .I_Mode_Sel    (I_Mode_Sel),
        .O_Pre_De      (O_Pre_De),
        .O_Pre_Vsync   (O_Pre_Vsync),
        .O_Pre_Hsync   (O_Pre_Hsync),
        .O_Post_De     (O_Post_De),
        .O_Post_Vsync  (O_Post_Vsync),
        .O_Post_Hsync  (O_Post_Hsync),
        .O_H_Cnt       (O_H_Cnt),
        .O_V_Cnt       (O_V_Cnt),
        .O_Frame_Start (O_Frame_Start),
        .O_Mode_Active (O_Mode_Active),
        .O_Tpg_Data    (O_Tpg_Data)
    );

    always #5 Pixl_CLK = ~Pixl_CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] mode;
        int         period;
        int         de_n;
        int         hs_start;
        int         hs_w;
        logic       hs_lvl;
    } line_vec_t;

    line_vec_t vecs [4];

    // Post path observer: Post must equal Pre from PRE_LEAD samples earlier.
    logic [2:0] pre_hist [PRE_LEAD];
    int hist_n      = 0;
    int post_bad    = 0;
    int post_active = 0;

    initial begin
        forever begin
            @(negedge Pixl_CLK);
            if (!Rst_n) begin
                hist_n = 0;
            end else begin
                if (hist_n >= PRE_LEAD) begin
                    if ({O_Post_De, O_Post_Vsync, O_Post_Hsync} !== pre_hist[PRE_LEAD-1]) post_bad++;
                    if (pre_hist[PRE_LEAD-1][2]) post_active++;
                end
                for (int i = PRE_LEAD - 1; i > 0; i--) pre_hist[i] = pre_hist[i-1];
                pre_hist[0] = {O_Pre_De, O_Pre_Vsync, O_Pre_Hsync};
                if (hist_n < PRE_LEAD) hist_n++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Pixl_CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_h(input string name, input int h);
        int n;
        n = 0;
        while (O_H_Cnt != CNT_W'(h) && n < 4000) begin
            tick();
            n++;
        end
        chk(name, 32'(O_H_Cnt), 32'(h));
    endtask

    task automatic measure_line(input logic hs_lvl, output int period, output int de_n,
                                output int hs_start, output int hs_w, output int fs_n);
        period = 0; de_n = 0; hs_start = -1; hs_w = 0; fs_n = 0;
        do begin
            if (O_Pre_De) de_n++;
            if (O_Frame_Start) fs_n++;
            if (O_Pre_Hsync == hs_lvl) begin
                if (hs_start < 0) hs_start = int'(O_H_Cnt);
                hs_w++;
            end
            tick();
            period++;
        end while (!(O_H_Cnt == '0 && O_V_Cnt == CNT_W'(1)) && period < 5000);
    endtask

    task automatic run_frame(input int sw_at, input logic [1:0] sw_sel, output int period,
                             output int de_n, output int vs_n, output logic [1:0] mode_last);
        period = 0; de_n = 0; vs_n = 0; mode_last = 2'd0;
        do begin
            if (O_Pre_De) de_n++;
            if (O_Pre_Vsync == 1'b0) vs_n++;
            mode_last = O_Mode_Active;
            if (period == sw_at) I_Mode_Sel = sw_sel;
            tick();
            period++;
        end while (!O_Frame_Start && period < 1000);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pre"},  32'({O_Pre_De, O_Pre_Vsync, O_Pre_Hsync}), 32'd0);
        chk({tag, "_post"}, 32'({O_Post_De, O_Post_Vsync, O_Post_Hsync}), 32'd0);
        chk({tag, "_cnt"},  32'({O_H_Cnt, O_V_Cnt}), 32'd0);
        chk({tag, "_fs"},   32'(O_Frame_Start), 32'd0);
        chk({tag, "_mode"}, 32'(O_Mode_Active), 32'd0);
        chk({tag, "_tpg"},  32'(O_Tpg_Data), 32'd0);
    endtask

    initial begin
        int period, de_n, hs_start, hs_w, fs_n, vs_n;
        logic [1:0] mode_last;

        vecs[0] = '{2'd0, 2'd0, 1688, 1280, 1328, 112, 1'b1};
        vecs[1] = '{2'd1, 2'd1, 1650, 1280, 1390, 40,  1'b1};
        vecs[2] = '{2'd3, 2'd1, 1650, 1280, 1390, 40,  1'b1};
        vecs[3] = '{2'd2, 2'd2, 24,   16,   18,   2,   1'b0};

        Rst_n = 1'b0;
        I_Enable = 1'b0;
        I_Mode_Sel = 2'd0;
        ticks(3);
        chk_reset_vals("reset");
        Rst_n = 1'b1;
        ticks(3);
        chk("idle_after_reset", 32'({O_Pre_De, O_Pre_Hsync, O_Frame_Start}), 32'd0);

        for (int i = 0; i < 4; i++) begin
            I_Enable = 1'b0;
            ticks(3);
            I_Mode_Sel = vecs[i].sel;
            I_Enable = 1'b1;
            ticks(2);
            chk($sformatf("v%0d_first_fs", i), 32'(O_Frame_Start), 32'd1);
            chk($sformatf("v%0d_first_hv", i), 32'({O_H_Cnt, O_V_Cnt}), 32'd0);
            chk($sformatf("v%0d_mode", i), 32'(O_Mode_Active), 32'(vecs[i].mode));
            measure_line(vecs[i].hs_lvl, period, de_n, hs_start, hs_w, fs_n);
            chk($sformatf("v%0d_line_period", i), 32'(period), 32'(vecs[i].period));
            chk($sformatf("v%0d_de_cycles", i), 32'(de_n), 32'(vecs[i].de_n));
            chk($sformatf("v%0d_hs_start", i), 32'(hs_start), 32'(vecs[i].hs_start));
            chk($sformatf("v%0d_hs_width", i), 32'(hs_w), 32'(vecs[i].hs_w));
            chk($sformatf("v%0d_fs_count", i), 32'(fs_n), 32'd1);
        end

        // Idle in a negative-polarity mode keeps syncs at their inactive (high) level.
        I_Enable = 1'b0;
        tick();
        chk("idle_neg_syncs", 32'({O_Pre_Vsync, O_Pre_Hsync}), 32'd3);
        chk("idle_neg_de_cnt", 32'({O_Pre_De, O_H_Cnt}), 32'd0);

        I_Mode_Sel = 2'd2;
        I_Enable = 1'b1;
        ticks(2);
        chk("m2_fs", 32'(O_Frame_Start), 32'd1);
        run_frame(100, 2'd3, period, de_n, vs_n, mode_last);
        chk("m2_frame_period", 32'(period), 32'd288);
        chk("m2_frame_de", 32'(de_n), 32'd128);
        chk("m2_frame_vsync", 32'(vs_n), 32'd24);
        chk("m2_mode_last_px", 32'(mode_last), 32'd2);
        chk("m2_invalid_sel_ignored", 32'(O_Mode_Active), 32'd2);
        run_frame(50, 2'd0, period, de_n, vs_n, mode_last);
        chk("m2_switch_frame_period", 32'(period), 32'd288);
        chk("m2_switch_mode_last_px", 32'(mode_last), 32'd2);
        chk("m0_after_switch_mode", 32'(O_Mode_Active), 32'd0);
        chk("m0_after_switch_hv", 32'({O_H_Cnt, O_V_Cnt}), 32'd0);
        measure_line(1'b1, period, de_n, hs_start, hs_w, fs_n);
        chk("m0_after_switch_period", 32'(period), 32'd1688);
        chk("m0_after_switch_de", 32'(de_n), 32'd1280);

        // Post pixel k is visible while Pre shows h = k + PRE_LEAD.
        wait_h("tpg_px0_wait", 5);
        chk("tpg_px0_de", 32'(O_Post_De), 32'd1);
`ifdef VTC_TPG_EN
        chk("tpg_px0", 32'(O_Tpg_Data), 32'hFFFFFF);
        wait_h("tpg_px159_wait", 164);
        chk("tpg_px159", 32'(O_Tpg_Data), 32'hFFFFFF);
        wait_h("tpg_px160_wait", 165);
        chk("tpg_px160", 32'(O_Tpg_Data), 32'hFFFF00);
        wait_h("tpg_px960_wait", 965);
        chk("tpg_px960", 32'(O_Tpg_Data), 32'h0000FF);
`else
        chk("tpg_off_px0", 32'(O_Tpg_Data), 32'd0);
        wait_h("tpg_px160_wait", 165);
        chk("tpg_off_px160", 32'(O_Tpg_Data), 32'd0);
`endif
        wait_h("tpg_px1279_wait", 1284);
        chk("tpg_px1279_de", 32'(O_Post_De), 32'd1);
        chk("tpg_px1279", 32'(O_Tpg_Data), 32'd0);
        wait_h("tpg_blank_wait", 1290);
        chk("tpg_blank_de", 32'(O_Post_De), 32'd0);
        chk("tpg_blank", 32'(O_Tpg_Data), 32'd0);

        wait_h("en_fall_wait", 100);
        I_Enable = 1'b0;
        tick();
        chk("en_fall_pre_de", 32'(O_Pre_De), 32'd0);
        chk("en_fall_cnt", 32'({O_H_Cnt, O_V_Cnt, O_Frame_Start}), 32'd0);
        chk("en_fall_post_drain", 32'(O_Post_De), 32'd1);
        ticks(4);
        chk("en_fall_post_last", 32'(O_Post_De), 32'd1);
        tick();
        chk("en_fall_post_done", 32'(O_Post_De), 32'd0);

        I_Mode_Sel = 2'd1;
        I_Enable = 1'b1;
        ticks(2);
        chk("m1_restart_fs", 32'(O_Frame_Start), 32'd1);
        chk("m1_restart_mode", 32'(O_Mode_Active), 32'd1);
        wait_h("rst_mid_wait", 700);
        chk("rst_mid_post_busy", 32'(O_Post_De), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        ticks(2);
        Rst_n = 1'b1;
        ticks(2);
        chk("rst_rel_fs", 32'(O_Frame_Start), 32'd1);
        chk("rst_rel_hv", 32'({O_H_Cnt, O_V_Cnt}), 32'd0);
        chk("rst_rel_mode", 32'(O_Mode_Active), 32'd1);
        ticks(20);

        chk("post_align_mismatches", 32'(post_bad), 32'd0);
        chk("post_align_active_seen", 32'(post_active > 1000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
